adc_spi_cfg_seq: RTL
====================

ADC_SPI_CFG_SEQ -- requirements
Module: adc_spi_cfg_seq

Interface
REQ-001 SHALL have parameter ADDR_W, 8, register-address field width.
REQ-002 SHALL have parameter DATA_W, 8, register-data field width.
REQ-003 SHALL have parameter NUM_INIT, 13, number of power-up table entries (0 allowed).
REQ-004 SHALL have parameter INIT_TABLE, all zeros, NUM_INIT*(ADDR_W+DATA_W) bits; entry k = {addr,data} at bits [(k+1)*FW-1 : k*FW], FW=ADDR_W+DATA_W.
REQ-005 SHALL have parameter CLK_DIV, 4, clk cycles per SPI bit (even, >=2).
REQ-006 SHALL have parameter CSB_GAP, 2, minimum csb-high cycles between frames (>=1).
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 sclk  output  1  SPI clock, idle low.
REQ-010 csb  output  1  SPI chip select, active low.
REQ-011 sdio  output  1  serial data to ADC, MSB first.
REQ-012 sdo  input  1  serial readback data from ADC.
REQ-013 init_done  output  1  high once the init table has been fully sent; stays high until reset.
REQ-014 cmd_valid / cmd_ready  input / output  1 / 1  runtime command handshake.
REQ-015 cmd_rw  input  1  1 = read, 0 = write.
REQ-016 cmd_addr, cmd_wdata  input  ADDR_W, DATA_W  command address and write data.
REQ-017 rsp_valid  output  1  one-cycle pulse on command completion.
REQ-018 rsp_rdata  output  DATA_W  data captured by the last read.

Function
REQ-019 States SHALL be LOAD, SHIFT, GAP, READY; LOAD/SHIFT/GAP serve both init and runtime frames.
REQ-020 Frame SHALL be FW bits {addr,data}, MSB first; for reads addr MSB forced to 1 and data field sent as zeros; for writes addr MSB as given.
REQ-021 LOAD: 1 cycle, csb high, frame latched into shift register.
REQ-022 SHIFT: FW*CLK_DIV cycles, csb low; each bit: sdio updated at bit start, sclk low for CLK_DIV/2 cycles then high for CLK_DIV/2.
REQ-023 sdo SHALL be sampled on the clk edge that drives sclk high, data-field bits only, shifted into rsp_rdata MSB first (reads only).
REQ-024 GAP: CSB_GAP cycles, csb high, sclk low, sdio low.
REQ-025 After reset deassertion, entries 0..NUM_INIT-1 SHALL be sent in order, then init_done rises on entry to READY; NUM_INIT=0 enters READY directly after one LOAD-skip cycle.
REQ-026 cmd_ready SHALL be high only in READY; command accepted when cmd_valid & cmd_ready; next state LOAD.
REQ-027 cmd_valid during init or an active frame SHALL be ignored (not queued).
REQ-028 rsp_valid SHALL pulse for exactly the first GAP cycle of each runtime frame; never for init frames.
REQ-029 rsp_rdata SHALL update only for read commands and hold value otherwise.
REQ-030 Runtime command latency: accept cycle -> csb low after 1 LOAD cycle; READY re-entered 1+FW*CLK_DIV+CSB_GAP cycles after accept.
REQ-031 Table index and bit counter SHALL be sized for NUM_INIT and FW with no wrap before completion.

Reset
REQ-032 rst high SHALL immediately force csb=1, sclk=0, sdio=0, init_done=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, state=LOAD, index=0.
REQ-033 rst asserted mid-frame SHALL abort the frame (csb high asynchronously); init restarts from entry 0 after release.

Verification
REQ-034 Defaults with NUM_INIT=2, entries {8'h00,8'h03},{8'h10,8'h00} -> two 16-bit frames, each csb low 64 cycles, 2-cycle gap; sdio pattern 0x0003 then 0x1000; init_done at cycle 134 after release.
REQ-035 Write cmd addr=8'h16 data=8'h05 in READY -> frame 0x1605, cmd_ready low 67 cycles, single rsp_valid pulse, rsp_rdata unchanged.
REQ-036 Read cmd addr=8'h17 with ADC model returning 8'hA5 -> frame addr byte 0x97, rsp_rdata=8'hA5 at rsp_valid.
REQ-037 cmd_valid held high throughout init -> no extra frame until READY; first accepted exactly at the cycle init_done rises.
REQ-038 rst pulse at bit 7 of init frame 1 -> csb high same cycle, outputs at reset values, full init restarts from entry 0.
REQ-039 NUM_INIT=0, CLK_DIV=2 -> init_done within 2 cycles, read frame lasts 32 SHIFT cycles.

Source files
------------

// File: rtl/adc_spi_cfg_seq.sv
// SPI configuration sequencer for an ADC: replays a power-up register table,
// then serves runtime single-register read/write commands over the same frame engine.
module adc_spi_cfg_seq #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int NUM_INIT = 13,
    parameter logic [(NUM_INIT > 0 ? NUM_INIT : 1)*(ADDR_W+DATA_W)-1:0] INIT_TABLE = '0,
    parameter int CLK_DIV  = 4,
    parameter int CSB_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              sclk,
    output logic              csb,
    output logic              sdio,
    input  logic              sdo,
    output logic              init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata
);
    localparam int FW    = ADDR_W + DATA_W;
    localparam int IDX_W = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(FW);
    localparam int GAP_W = (CSB_GAP > 1) ? $clog2(CSB_GAP) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'((NUM_INIT > 0) ? NUM_INIT - 1 : 0);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_PRE    = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FW - 1);
    localparam logic [BIT_W-1:0] DATA_START = BIT_W'(ADDR_W);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(CSB_GAP - 1);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_READY = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [FW-1:0]    shreg;
    logic             runtime;
    logic             is_read;

    // Pins are decoded from state registers only, so reset reaches them asynchronously.
    assign csb       = (state != S_SHIFT);
    assign sclk      = (state == S_SHIFT) && (div_cnt >= DIV_HALF);
    assign sdio      = (state == S_SHIFT) && shreg[FW-1];
    assign cmd_ready = (state == S_READY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            idx       <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            runtime   <= 1'b0;
            is_read   <= 1'b0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_LOAD: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    // Runtime frames were already latched on accept.
                    if (runtime) begin
                        state <= S_SHIFT;
                    end else if (NUM_INIT == 0) begin
                        state     <= S_READY;
                        init_done <= 1'b1;
                    end else begin
                        shreg <= INIT_TABLE[int'(idx)*FW +: FW];
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                    if (div_cnt == DIV_PRE && is_read && bit_cnt >= DATA_START)
                        rsp_rdata <= {rsp_rdata[DATA_W-2:0], sdo};
                    if (div_cnt == DIV_LAST) begin
                        shreg <= {shreg[FW-2:0], 1'b0};
                        if (bit_cnt == BIT_LAST) begin
                            state     <= S_GAP;
                            gap_cnt   <= '0;
                            rsp_valid <= runtime;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (runtime || idx == LAST_IDX) begin
                            state     <= S_READY;
                            init_done <= 1'b1;
                            runtime   <= 1'b0;
                            is_read   <= 1'b0;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (cmd_valid) begin
                        runtime <= 1'b1;
                        is_read <= cmd_rw;
                        // Reads set the address MSB and clock out a zero data field.
                        shreg   <= cmd_rw ? {1'b1, cmd_addr[ADDR_W-2:0], {DATA_W{1'b0}}}
                                          : {cmd_addr, cmd_wdata};
                        state   <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule
